// File: rtl/bus_dma_copy_if.sv
// CPU memory bus (24-bit AB, 8-bit DO/DI, WE, RDY) shared by the initiator and the RAM responder.
interface bus_dma_copy_if;
  logic [23:0] AB;
  logic [7:0]  DO;
  logic [7:0]  DI;
  logic        WE;
  logic        RDY;

  modport master (output AB, output DO, output WE, input DI, input RDY);
  modport slave  (input AB, input DO, input WE, output DI, output RDY);
endinterface

// File: rtl/bus_dma_copy.sv
// Bus-master block copy engine: one read then one write per byte, aborting before any write into the vector region.
// Optional constant-fill mode is compiled in when DMA_FILL_EN is defined.
module bus_dma_copy #(
  parameter int          LEN_W    = 17,
  parameter logic [23:0] VEC_BASE = 24'hFFFFF0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      src,
  input  logic [23:0]      dst,
  input  logic [LEN_W-1:0] len,
`ifdef DMA_FILL_EN
  input  logic             fill,
  input  logic [7:0]       fill_val,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  bus_dma_copy_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [23:0]      src_q, src_d;
  logic [23:0]      dst_q, dst_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             dst_in_vec;
  logic [7:0]       wr_data;
  state_t           after_write;

`ifdef DMA_FILL_EN
  logic             fill_q, fill_d;
  logic [7:0]       fill_val_q, fill_val_d;
`endif

  // Evaluated against the live pointer so a wrap into the vectors mid-transfer also aborts.
  assign dst_in_vec = (dst_q >= VEC_BASE);

`ifdef DMA_FILL_EN
  assign wr_data     = fill_q ? fill_val_q : bus.DI;
  assign after_write = fill_q ? S_WRITE : S_READ;
`else
  assign wr_data     = bus.DI;
  assign after_write = S_READ;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef DMA_FILL_EN
      fill_q     <= 1'b0;
      fill_val_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef DMA_FILL_EN
      fill_q     <= fill_d;
      fill_val_q <= fill_val_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef DMA_FILL_EN
    fill_d     = fill_q;
    fill_val_d = fill_val_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (len != '0) begin
            src_d = src;
            dst_d = dst;
            cnt_d = len;
`ifdef DMA_FILL_EN
            fill_d     = fill;
            fill_val_d = fill_val;
            state_d    = fill ? S_WRITE : S_READ;
`else
            state_d    = S_READ;
`endif
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        if (bus.RDY) state_d = S_WRITE;
      end
      S_WRITE: begin
        // The abort does not wait for RDY: no bus cycle is issued.
        if (dst_in_vec) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (bus.RDY) begin
          src_d   = src_q + 24'd1;
          dst_d   = dst_q + 24'd1;
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? S_DONE : after_write;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    bus.AB = '0;
    bus.WE = 1'b0;
    bus.DO = '0;
    case (state_q)
      S_READ: begin
        busy   = 1'b1;
        bus.AB = src_q;
      end
      S_WRITE: begin
        busy   = 1'b1;
        bus.AB = dst_q;
        bus.WE = !dst_in_vec;
        bus.DO = wr_data;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign err = err_q;

endmodule

// File: tb/tb_bus_dma_copy.sv
// Randomized bench for bus_dma_copy: RAM responder with registered read, byte-wise reference model, bus-cycle scoreboard.
module tb_bus_dma_copy;
  localparam int          LEN_W    = 17;
  localparam logic [23:0] VEC_BASE = 24'hFFFFF0;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [23:0]      src;
  logic [23:0]      dst;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             err;
  logic             rdy;
  logic [7:0]       di_q = 8'h00;
`ifdef DMA_FILL_EN
  logic             fill;
  logic [7:0]       fill_val;
`endif

  bus_dma_copy_if bus ();

  always #5 clk = ~clk;

  bus_dma_copy #(.LEN_W(LEN_W), .VEC_BASE(VEC_BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src      (src),
    .dst      (dst),
    .len      (len),
`ifdef DMA_FILL_EN
    .fill     (fill),
    .fill_val (fill_val),
`endif
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bus      (bus)
  );

  // RAM responder: 128 KiB, aliased over the 24-bit space; unwritten bytes read a fixed hash.
  bit [7:0]  ram_wr  [0:131071];
  bit        ram_vld [0:131071];
  logic        bd_en = 1'b0;
  logic [16:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;
  logic [7:0]  exp_ram [0:131071];

  assign bus.RDY = rdy;
  assign bus.DI  = di_q;

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    logic [16:0] i;
    i = a[16:0];
    if (ram_vld[i]) return ram_wr[i];
    return (a[7:0] * 8'd37) ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h5C;
  endfunction

  always @(posedge clk) begin
    if (bd_en) begin
      ram_wr[bd_addr]  <= bd_data;
      ram_vld[bd_addr] <= 1'b1;
    end else if (bus.RDY && bus.WE) begin
      ram_wr[bus.AB[16:0]]  <= bus.DO;
      ram_vld[bus.AB[16:0]] <= 1'b1;
    end
    if (bus.RDY) di_q <= mem_rd(bus.AB);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic poke_mem(input logic [23:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_en = 1'b1; bd_addr = a[16:0]; bd_data = d;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  task automatic snapshot();
    for (int i = 0; i < 131072; i++) exp_ram[i] = mem_rd(24'(i));
  endtask

  task automatic compare_ram(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 131072; i++) if (mem_rd(24'(i)) !== exp_ram[i]) bad++;
    check(tag, bad, 0);
  endtask

  // One transfer: builds the expected byte stream and bus-cycle order, drives RDY, scoreboards every cycle.
  task automatic run_xfer(input string name, input logic [23:0] s, input logic [23:0] d,
                          input logic [LEN_W-1:0] l, input int stall_pct, input logic [63:0] stall_mask,
                          input int poke_at, input bit fil, input logic [7:0] fv);
    logic [23:0] rdq[$];
    logic [23:0] waq[$];
    logic [7:0]  wdq[$];
    logic [23:0] sa, da, ea;
    logic [7:0]  b, ed;
    bit          abort, seen_done, r;
    int          nwr, n, stalls, want_lat;

    snapshot();
    abort = 0; nwr = 0;
    for (int i = 0; i < int'(l); i++) begin
      sa = s + 24'(i);
      da = d + 24'(i);
      if (!fil) rdq.push_back(sa);
      if (da >= VEC_BASE) begin
        abort = 1;
        rdq.push_back(da);
        break;
      end
      b = fil ? fv : exp_ram[sa[16:0]];
      exp_ram[da[16:0]] = b;
      waq.push_back(da);
      wdq.push_back(b);
      nwr++;
    end

    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1; rdy = 1'b1;
`ifdef DMA_FILL_EN
    fill = fil; fill_val = fv;
`endif
    n = 0; stalls = 0; seen_done = 0;
    while (!seen_done && n < 400) begin
      @(negedge clk);
      n++;
      start = (n == poke_at);
      if (start) begin
        src = $urandom; dst = $urandom; len = LEN_W'($urandom_range(1, 50));
      end
      r = !((n < 64) && stall_mask[n]) && ($urandom_range(99) >= stall_pct);
      rdy = r;
      if (n == 1) check({name, "_err_cleared"}, err, 0);
      if (done) begin
        seen_done = 1;
        check({name, "_done_busy"}, busy, 0);
        check({name, "_done_we"}, bus.WE, 0);
        check({name, "_done_do"}, bus.DO, 0);
      end else begin
        if (busy !== 1'b1) check({name, "_busy"}, busy, 1);
        if (!r) stalls++;
        else if (bus.WE) begin
          if (waq.size() == 0) check({name, "_extra_wr"}, 1, 0);
          else begin
            ea = waq.pop_front();
            ed = wdq.pop_front();
            check({name, "_wr_ab"}, bus.AB, ea);
            check({name, "_wr_do"}, bus.DO, ed);
          end
        end else begin
          if (rdq.size() == 0) check({name, "_extra_rd"}, 1, 0);
          else begin
            ea = rdq.pop_front();
            check({name, "_rd_ab"}, bus.AB, ea);
          end
        end
      end
    end
    if (!seen_done) check({name, "_timeout"}, 0, 1);

    if (l == 0) want_lat = 1;
    else want_lat = 1 + (fil ? 1 : 2) * (nwr + (abort ? 1 : 0)) + stalls;
    check({name, "_latency"}, n, want_lat);
    check({name, "_err"}, err, abort);
    check({name, "_rd_left"}, rdq.size(), 0);
    check({name, "_wr_left"}, waq.size(), 0);
    compare_ram({name, "_ram"});

    // A start during DONE must be ignored.
    if (poke_at > 0) begin
      start = 1'b1; src = $urandom; dst = $urandom; len = LEN_W'(5);
    end
    @(negedge clk);
    start = 1'b0;
    check({name, "_after_done"}, done, 0);
    check({name, "_after_busy"}, busy, 0);
    $display("xfer %s src=%06h dst=%06h len=%0d cycles=%0d stalls=%0d abort=%0d", name, s, d, l, n, stalls, abort);
  endtask

  task automatic run_reset_test();
    int n, wcount;
    snapshot();
    exp_ram[17'h2000] = exp_ram[17'h1000];
    exp_ram[17'h2001] = exp_ram[17'h1001];
    @(negedge clk);
    src = 24'h001000; dst = 24'h002000; len = LEN_W'(8); start = 1'b1; rdy = 1'b1;
`ifdef DMA_FILL_EN
    fill = 1'b0;
`endif
    n = 0; wcount = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (bus.WE) wcount++;
      if (wcount == 3) begin
        reset = 1'b1;
        rdy = 1'b0;
        break;
      end
      rdy = 1'b1;
    end
    check("rst_reached_write3", wcount, 3);
    @(negedge clk);
    reset = 1'b0; rdy = 1'b1;
    check("rst_we", bus.WE, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0) check("rst_no_done", done, 0);
    end
    compare_ram("rst_ram");
    $display("xfer reset_mid src=001000 dst=002000 len=8 cycles=%0d", n);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rdy = 1'b1;
    src = '0; dst = '0; len = '0;
`ifdef DMA_FILL_EN
    fill = 1'b0; fill_val = '0;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_we", bus.WE, 0);
    check("reset_ab", bus.AB, 0);
    check("reset_do", bus.DO, 0);
    reset = 1'b0;

    poke_mem(24'h000100, 8'h11);
    poke_mem(24'h000101, 8'h22);
    poke_mem(24'h000102, 8'h33);
    poke_mem(24'h000103, 8'h44);
    run_xfer("basic", 24'h000100, 24'h000200, LEN_W'(4), 0, 64'd0, 0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) check("basic_byte", mem_rd(24'h000200 + 24'(i)), 32'h11 * (i + 1));

    for (int i = 0; i < 4; i++) poke_mem(24'h000200 + 24'(i), 8'h00);
    run_xfer("stall", 24'h000100, 24'h000200, LEN_W'(4), 0, 64'h18E, 0, 1'b0, 8'h00);

    run_xfer("zero_len", 24'h000100, 24'h000500, LEN_W'(0), 0, 64'd0, 0, 1'b0, 8'h00);
    run_xfer("abort_vec", 24'h000100, 24'hFFFFEE, LEN_W'(4), 0, 64'd0, 0, 1'b0, 8'h00);
    run_xfer("after_abort", 24'h000104, 24'h000600, LEN_W'(1), 0, 64'd0, 0, 1'b0, 8'h00);
    run_xfer("wrap_src", 24'hFFFFFE, 24'h000300, LEN_W'(4), 0, 64'd0, 3, 1'b0, 8'h00);
    run_reset_test();

    for (int k = 0; k < 12; k++) begin
      run_xfer("rand_copy", 24'($urandom_range(0, 131071)), 24'($urandom_range(0, 131071)),
               LEN_W'($urandom_range(1, 10)), 30, 64'd0, $urandom_range(0, 6), 1'b0, 8'h00);
    end
    for (int k = 0; k < 4; k++) begin
      run_xfer("rand_abort", 24'($urandom_range(0, 65535)), VEC_BASE - 24'($urandom_range(0, 3)),
               LEN_W'($urandom_range(1, 6)), 0, 64'd0, 0, 1'b0, 8'h00);
    end

`ifdef DMA_FILL_EN
    run_xfer("fill", 24'h000000, 24'h000400, LEN_W'(3), 0, 64'd0, 0, 1'b1, 8'hA5);
    for (int i = 0; i < 3; i++) check("fill_byte", mem_rd(24'h000400 + 24'(i)), 32'hA5);
    for (int k = 0; k < 4; k++) begin
      run_xfer("rand_fill", 24'($urandom), 24'($urandom_range(0, 131071)),
               LEN_W'($urandom_range(1, 8)), 25, 64'd0, 0, 1'b1, 8'($urandom));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
